// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampled UART receiver with 3-sample majority voting,
// parity/framing/break detection and a valid/ready RX FIFO.
module uart_rx_os #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int BAUD_RATE  = 115200,
   parameter int DATA_BITS  = 8,
   parameter int PARITY     = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          rx,
   output logic [DATA_BITS-1:0]          rx_data,
   output logic                          rx_perr,
   output logic                          rx_ferr,
   output logic                          rx_valid,
   input  logic                          rx_ready,
   output logic                          overrun,
   output logic                          break_det,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

   localparam int OS_DIV = CLK_FREQ / (BAUD_RATE * 16);
   localparam int TW     = (OS_DIV > 1) ? $clog2(OS_DIV) : 1;
   localparam int AW     = $clog2(FIFO_DEPTH);
   localparam int CW     = AW + 1;
   localparam int WW     = DATA_BITS + 2;

   if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_err_db
      $error("uart_rx_os: DATA_BITS must be 5..9");
   end
   if (PARITY < 0 || PARITY > 2) begin : g_err_par
      $error("uart_rx_os: PARITY must be 0, 1 or 2");
   end
   if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_err_stop
      $error("uart_rx_os: STOP_BITS must be 1 or 2");
   end
   if (FIFO_DEPTH < 2 || (1 << AW) != FIFO_DEPTH) begin : g_err_fifo
      $error("uart_rx_os: FIFO_DEPTH must be a power of 2, >= 2");
   end
   if (OS_DIV < 1) begin : g_err_div
      $error("uart_rx_os: CLK_FREQ too low for 16x oversampling");
   end

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRKWAIT
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic                 r_rx_m;
   logic                 r_rx_s;
   logic                 r_rx_p;
   logic [TW-1:0]        r_tick_cnt;
   logic [3:0]           r_smp;
   logic                 r_s7;
   logic                 r_s8;
   logic [3:0]           r_bit_idx;
   logic [DATA_BITS-1:0] r_shift;
   logic                 r_par_rx;
   logic                 r_ferr;
   logic                 r_push;
   logic [WW-1:0]        r_word;
   logic                 r_break_det;
   logic                 r_overrun;
   logic [WW-1:0]        r_mem [FIFO_DEPTH];
   logic [AW-1:0]        r_wr_ptr;
   logic [AW-1:0]        r_rd_ptr;
   logic [CW-1:0]        r_count;

   logic                 w_start;
   logic                 w_tick;
   logic                 w_s9;
   logic                 w_s15;
   logic                 w_maj;
   logic                 w_last_data;
   logic                 w_last_stop;
   logic                 w_perr;
   logic                 w_zero;
   logic                 w_push_req;
   logic                 w_brk_req;
   logic [WW-1:0]        w_word;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_wr;

   assign w_start     = (r_state == S_IDLE) && r_rx_p && !r_rx_s;
   assign w_tick      = (r_tick_cnt == TW'(OS_DIV - 1));
   assign w_s9        = w_tick && (r_smp == 4'd9);
   assign w_s15       = w_tick && (r_smp == 4'd15);
   assign w_maj       = (r_s7 & r_s8) | (r_s7 & r_rx_s) | (r_s8 & r_rx_s);
   assign w_last_data = (r_bit_idx == 4'(DATA_BITS - 1));
   assign w_last_stop = (r_bit_idx == 4'(STOP_BITS - 1));
   assign w_perr      = (PARITY != 0) &&
                        (r_par_rx != ((^r_shift) ^ (PARITY == 1)));
   assign w_zero      = (r_shift == '0) && ((PARITY == 0) || !r_par_rx);

   // Two-flop synchroniser plus a delayed copy for falling-edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rx_m <= 1'b1;
         r_rx_s <= 1'b1;
         r_rx_p <= 1'b1;
      end else begin
         r_rx_m <= rx;
         r_rx_s <= r_rx_m;
         r_rx_p <= r_rx_s;
      end
   end

   // Oversampling tick and sample-index counters, realigned on a start edge
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_tick_cnt <= '0;
         r_smp      <= '0;
      end else if (w_start) begin
         r_tick_cnt <= '0;
         r_smp      <= '0;
      end else if (w_tick) begin
         r_tick_cnt <= '0;
         r_smp      <= r_smp + 4'd1;
      end else begin
         r_tick_cnt <= r_tick_cnt + TW'(1);
      end
   end

   // Capture samples 7 and 8; sample 9 is taken live for the vote
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s7 <= 1'b1;
         r_s8 <= 1'b1;
      end else if (w_tick) begin
         if (r_smp == 4'd7) r_s7 <= r_rx_s;
         if (r_smp == 4'd8) r_s8 <= r_rx_s;
      end
   end

   // FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // FSM next-state logic
   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE:    if (w_start) w_next = S_START;
         S_START: begin
            if (w_s9 && w_maj) w_next = S_IDLE;
            else if (w_s15)    w_next = S_DATA;
         end
         S_DATA: begin
            if (w_s15 && w_last_data)
               w_next = (PARITY != 0) ? S_PAR : S_STOP;
         end
         S_PAR:     if (w_s15) w_next = S_STOP;
         S_STOP: begin
            if (w_brk_req)       w_next = S_BRKWAIT;
            else if (w_push_req) w_next = S_IDLE;
         end
         S_BRKWAIT: if (r_rx_s) w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

   // FSM outputs: frame completion or break at a stop-bit vote
   always_comb begin
      w_push_req = 1'b0;
      w_brk_req  = 1'b0;
      w_word     = {r_ferr | ~w_maj, w_perr, r_shift};
      if (r_state == S_STOP && w_s9) begin
         if (r_bit_idx == 4'd0 && w_zero && !w_maj) w_brk_req = 1'b1;
         else if (w_last_stop)                      w_push_req = 1'b1;
      end
   end

   // Frame datapath: bit index, LSB-first shifter, parity and stop flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_par_rx  <= 1'b0;
         r_ferr    <= 1'b0;
      end else if (w_start) begin
         r_bit_idx <= '0;
         r_shift   <= '0;
         r_par_rx  <= 1'b0;
         r_ferr    <= 1'b0;
      end else begin
         unique case (r_state)
            S_DATA: begin
               if (w_s9)
                  r_shift <= {w_maj, r_shift[DATA_BITS-1:1]};
               if (w_s15)
                  r_bit_idx <= w_last_data ? 4'd0 : r_bit_idx + 4'd1;
            end
            S_PAR: if (w_s9) r_par_rx <= w_maj;
            S_STOP: begin
               if (w_s9 && !w_maj) r_ferr <= 1'b1;
               if (w_s15)          r_bit_idx <= r_bit_idx + 4'd1;
            end
            default: ;
         endcase
      end
   end

   // Register the completed word and the break pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_push      <= 1'b0;
         r_word      <= '0;
         r_break_det <= 1'b0;
      end else begin
         r_push      <= w_push_req;
         r_break_det <= w_brk_req;
         if (w_push_req) r_word <= w_word;
      end
   end

   assign w_pop  = rx_valid && rx_ready;
   assign w_full = (r_count == CW'(FIFO_DEPTH));
   assign w_wr   = r_push && (!w_full || w_pop);

   // FIFO storage; a full FIFO still accepts a push that coincides with a pop
   always_ff @(posedge clk) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_word;
   end

   // FIFO pointers, occupancy and overrun pulse
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         r_count   <= r_count + CW'(w_wr) - CW'(w_pop);
         r_overrun <= r_push && w_full && !w_pop;
      end
   end

   assign rx_valid   = (r_count != '0);
   assign rx_data    = rx_valid ? r_mem[r_rd_ptr][DATA_BITS-1:0] : '0;
   assign rx_perr    = rx_valid && r_mem[r_rd_ptr][DATA_BITS];
   assign rx_ferr    = rx_valid && r_mem[r_rd_ptr][DATA_BITS+1];
   assign fifo_count = r_count;
   assign overrun    = r_overrun;
   assign break_det  = r_break_det;

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: directed bench for uart_rx_os, one 8N1 instance and one
// 7E2 instance, both at 2 clocks per oversample tick (32 clocks per bit).
module tb_uart_rx_os;

   localparam int CLKF = 3_200_000;
   localparam int BAUD = 100_000;
   localparam int BIT  = 32;
   localparam int DEP  = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_a = 1'b1;
   logic       rx_b = 1'b1;
   logic       rdy_a = 1'b0;
   logic       rdy_b = 1'b0;
   logic [7:0] data_a;
   logic [6:0] data_b;
   logic       perr_a, ferr_a, val_a, ovr_a, brk_a;
   logic       perr_b, ferr_b, val_b, ovr_b, brk_b;
   logic [2:0] cnt_a, cnt_b;

   int n_cmp = 0;
   int n_mis = 0;
   int n_ovr_a = 0;
   int n_brk_a = 0;
   int fidx = 0;
   int rise_idx = -1;
   logic vprev = 1'b0;

   always #5 clk = ~clk;

   uart_rx_os #(
      .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(8),
      .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEP)
   ) u_a (
      .clk(clk), .rst_n(rst_n), .rx(rx_a),
      .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a),
      .rx_valid(val_a), .rx_ready(rdy_a), .overrun(ovr_a),
      .break_det(brk_a), .fifo_count(cnt_a)
   );

   uart_rx_os #(
      .CLK_FREQ(CLKF), .BAUD_RATE(BAUD), .DATA_BITS(7),
      .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEP)
   ) u_b (
      .clk(clk), .rst_n(rst_n), .rx(rx_b),
      .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b),
      .rx_valid(val_b), .rx_ready(rdy_b), .overrun(ovr_b),
      .break_det(brk_b), .fifo_count(cnt_b)
   );

   always @(negedge clk) begin
      if (ovr_a) n_ovr_a++;
      if (brk_a) n_brk_a++;
      if (val_a && !vprev) rise_idx = fidx;
      vprev = val_a;
   end

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // n frame bits LSB first, then two idle bit-times; rdy_a pulses at step pop_at
   task automatic send(input bit b, input int n, input logic [15:0] v,
                       input int pop_at);
      logic [15:0] vv;
      vv = v;
      for (int i = 0; i < (n + 2) * BIT; i++) begin
         logic lv;
         lv = (i < n * BIT) ? vv[i / BIT] : 1'b1;
         if (b) rx_b = lv;
         else   rx_a = lv;
         rdy_a = (i == pop_at);
         fidx = i;
         @(posedge clk);
         #1;
      end
      rdy_a = 1'b0;
   endtask

   task automatic pop_a();
      rdy_a = 1'b1;
      wait_clk(1);
      rdy_a = 1'b0;
   endtask

   task automatic pop_b();
      rdy_b = 1'b1;
      wait_clk(1);
      rdy_b = 1'b0;
   endtask

   function automatic logic [15:0] fa(input logic [7:0] d);
      return {6'b0, 1'b1, d, 1'b0};
   endfunction

   function automatic logic [15:0] fb(input logic [6:0] d, input logic p,
                                      input logic s2);
      return {5'b0, s2, 1'b1, p, d, 1'b0};
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      int L;
      int o0;
      logic [7:0] exp_q [4];

      wait_clk(4);
      chk("rst_valid_a", val_a, 0);
      chk("rst_count_a", cnt_a, 0);
      chk("rst_data_a", data_a, 0);
      chk("rst_perr_a", perr_a, 0);
      chk("rst_ferr_a", ferr_a, 0);
      chk("rst_ovr_a", ovr_a, 0);
      chk("rst_brk_a", brk_a, 0);
      chk("rst_valid_b", val_b, 0);
      rst_n = 1'b1;
      wait_clk(4);

      send(0, 10, fa(8'hA5), -1);
      L = rise_idx;
      chk("t1_valid", val_a, 1);
      chk("t1_data", data_a, 8'hA5);
      chk("t1_perr", perr_a, 0);
      chk("t1_ferr", ferr_a, 0);
      chk("t1_count", cnt_a, 1);
      chk("t1_latency_ok", (L >= 300 && L <= 336), 1);
      pop_a();
      chk("t1_count_pop", cnt_a, 0);

      send(1, 11, fb(7'h41, 1'b1, 1'b1), -1);
      chk("t2_data", data_b, 7'h41);
      chk("t2_perr1", perr_b, 1);
      chk("t2_ferr", ferr_b, 0);
      pop_b();
      send(1, 11, fb(7'h41, 1'b0, 1'b1), -1);
      chk("t2_data2", data_b, 7'h41);
      chk("t2_perr0", perr_b, 0);
      pop_b();

      send(1, 11, fb(7'h3C, 1'b0, 1'b0), -1);
      chk("t3_data", data_b, 7'h3C);
      chk("t3_ferr", ferr_b, 1);
      chk("t3_perr", perr_b, 0);
      chk("t3_count", cnt_b, 1);
      pop_b();
      send(1, 11, fb(7'h55, 1'b0, 1'b1), -1);
      chk("t3_data2", data_b, 7'h55);
      chk("t3_ferr2", ferr_b, 0);
      chk("t3_perr2", perr_b, 0);
      pop_b();
      chk("t3_count_end", cnt_b, 0);

      rx_a = 1'b0;
      wait_clk(10);
      rx_a = 1'b1;
      wait_clk(3 * BIT);
      chk("t4_glitch_count", cnt_a, 0);
      chk("t4_glitch_valid", val_a, 0);
      chk("t4_glitch_brk", n_brk_a, 0);
      rx_a = 1'b0;
      wait_clk(12 * BIT);
      chk("t4_brk_pulses", n_brk_a, 1);
      chk("t4_brk_count", cnt_a, 0);
      rx_a = 1'b1;
      wait_clk(2 * BIT);
      chk("t4_brk_pulses_hi", n_brk_a, 1);
      send(0, 10, fa(8'hC3), -1);
      chk("t4_after_data", data_a, 8'hC3);
      chk("t4_after_ferr", ferr_a, 0);
      pop_a();

      o0 = n_ovr_a;
      send(0, 10, fa(8'h11), -1);
      send(0, 10, fa(8'h22), -1);
      send(0, 10, fa(8'h33), -1);
      send(0, 10, fa(8'h44), -1);
      send(0, 10, fa(8'h55), -1);
      chk("t5_full_count", cnt_a, DEP);
      chk("t5_overrun", n_ovr_a - o0, 1);
      chk("t5_head", data_a, 8'h11);
      send(0, 10, fa(8'h66), L - 1);
      chk("t5_pp_count", cnt_a, DEP);
      chk("t5_pp_overrun", n_ovr_a - o0, 1);
      exp_q[0] = 8'h22;
      exp_q[1] = 8'h33;
      exp_q[2] = 8'h44;
      exp_q[3] = 8'h66;
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("t5_drain%0d", k), data_a, exp_q[k]);
         pop_a();
      end
      chk("t5_empty", cnt_a, 0);

      send(0, 10, fa(8'h77), -1);
      chk("t6_pre_count", cnt_a, 1);
      rx_a = 1'b0;
      wait_clk(BIT);
      rx_a = 1'b1;
      wait_clk(2 * BIT + 16);
      rst_n = 1'b0;
      wait_clk(3);
      chk("t6_rst_count", cnt_a, 0);
      chk("t6_rst_valid", val_a, 0);
      chk("t6_rst_data", data_a, 0);
      rst_n = 1'b1;
      wait_clk(2 * BIT);
      chk("t6_idle_count", cnt_a, 0);
      send(0, 10, fa(8'h0F), -1);
      chk("t6_data", data_a, 8'h0F);
      chk("t6_count", cnt_a, 1);
      chk("t6_flags", {perr_a, ferr_a}, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
